// File: rtl/gpu_fill_engine_pkg.sv
// -----------------------------------------------------------------------------
// gpu_fill_engine_pkg
//   Shared definitions for the rectangle fill engine: screen coordinate widths,
//   last valid screen column/row, the fill FSM state encoding and the helpers
//   that clamp a coordinate onto the visible screen.
// -----------------------------------------------------------------------------
package gpu_fill_engine_pkg;

  localparam int WIDTH_BITS  = 10;
  localparam int HEIGHT_BITS = 9;

  // Last valid column/row of the 640x480 screen.
  localparam logic [WIDTH_BITS-1:0]  GPU_MAX_X = 10'd639;
  localparam logic [HEIGHT_BITS-1:0] GPU_MAX_Y = 9'd479;

  typedef enum logic [1:0] {
    FILL_IDLE = 2'd0,
    FILL_RUN  = 2'd1,
    FILL_DONE = 2'd2
  } fill_state_e;

  function automatic logic [WIDTH_BITS-1:0] clamp_x(input logic [WIDTH_BITS-1:0] v);
    return (v > GPU_MAX_X) ? GPU_MAX_X : v;
  endfunction

  function automatic logic [HEIGHT_BITS-1:0] clamp_y(input logic [HEIGHT_BITS-1:0] v);
    return (v > GPU_MAX_Y) ? GPU_MAX_Y : v;
  endfunction

endpackage : gpu_fill_engine_pkg

// File: rtl/gpu_fill_engine.sv
// -----------------------------------------------------------------------------
// gpu_fill_engine
//   Raster-scan rectangle fill generator. Given two opposite corners it emits
//   one pixel coordinate per cycle, left-to-right then top-to-bottom, and
//   yields to the line rasterizer whenever that block owns the pixel bus.
//
// Ports
//   clk            system clock, rising edge
//   n_rst          asynchronous active-low reset
//   start_i        request a fill (sampled in IDLE only)
//   abort_i        cancel the fill in progress
//   x1_i, y1_i     corner A
//   x2_i, y2_i     corner B
//   line_active_i  line rasterizer owns the pixel bus this cycle (stall)
//   x_fill_o       current fill pixel x (registered)
//   y_fill_o       current fill pixel y (registered)
//   fill_active    x_fill_o/y_fill_o hold a valid pixel
//   busy_o         fill in progress (state is not IDLE)
//   done_o         one-cycle pulse after the last pixel is consumed
// -----------------------------------------------------------------------------
module gpu_fill_engine
  import gpu_fill_engine_pkg::*;
(
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [WIDTH_BITS-1:0]  x1_i,
  input  logic [HEIGHT_BITS-1:0] y1_i,
  input  logic [WIDTH_BITS-1:0]  x2_i,
  input  logic [HEIGHT_BITS-1:0] y2_i,
  input  logic                   line_active_i,
  output logic [WIDTH_BITS-1:0]  x_fill_o,
  output logic [HEIGHT_BITS-1:0] y_fill_o,
  output logic                   fill_active,
  output logic                   busy_o,
  output logic                   done_o
);

  fill_state_e            state_q;
  logic [WIDTH_BITS-1:0]  x_q, xmin_q, xmax_q;
  logic [HEIGHT_BITS-1:0] y_q, ymin_q, ymax_q;
  logic                   fill_active_q;
  logic                   done_q;

  // Normalised, clamped bounds of the requested rectangle. Clamping after the
  // min/max gives the same result as clamping each corner first.
  logic [WIDTH_BITS-1:0]  xmin_d, xmax_d;
  logic [HEIGHT_BITS-1:0] ymin_d, ymax_d;

  assign xmin_d = clamp_x((x1_i < x2_i) ? x1_i : x2_i);
  assign xmax_d = clamp_x((x1_i < x2_i) ? x2_i : x1_i);
  assign ymin_d = clamp_y((y1_i < y2_i) ? y1_i : y2_i);
  assign ymax_d = clamp_y((y1_i < y2_i) ? y2_i : y1_i);

  // NOTE: all state, including the latched bounds, is updated with
  // non-blocking assignments so every branch sees the pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= FILL_IDLE;
      x_q           <= '0;
      y_q           <= '0;
      xmin_q        <= '0;
      xmax_q        <= '0;
      ymin_q        <= '0;
      ymax_q        <= '0;
      fill_active_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      // NOTE: done_q defaults low each cycle so it can only ever be a pulse;
      // the DONE branch below does not need to clear it explicitly.
      done_q <= 1'b0;
      case (state_q)
        FILL_IDLE: begin
          if (start_i) begin
            xmin_q        <= xmin_d;
            xmax_q        <= xmax_d;
            ymin_q        <= ymin_d;
            ymax_q        <= ymax_d;
            x_q           <= xmin_d;
            y_q           <= ymin_d;
            fill_active_q <= 1'b1;
            state_q       <= FILL_RUN;
          end
        end
        FILL_RUN: begin
          // Abort wins over both consume and stall.
          if (abort_i) begin
            fill_active_q <= 1'b0;
            state_q       <= FILL_IDLE;
          end else if (!line_active_i) begin
            if (x_q < xmax_q) begin
              x_q <= x_q + 1'b1;
            end else if (y_q < ymax_q) begin
              x_q <= xmin_q;
              y_q <= y_q + 1'b1;
            end else begin
              fill_active_q <= 1'b0;
              done_q        <= 1'b1;
              state_q       <= FILL_DONE;
            end
          end
        end
        FILL_DONE: state_q <= FILL_IDLE;
        default:   state_q <= FILL_IDLE;
      endcase
    end
  end

  assign x_fill_o    = x_q;
  assign y_fill_o    = y_q;
  assign fill_active = fill_active_q;
  assign done_o      = done_q;
  assign busy_o      = (state_q != FILL_IDLE);

endmodule : gpu_fill_engine

// File: tb/tb_gpu_fill_engine.sv
// -----------------------------------------------------------------------------
// tb_gpu_fill_engine
//   Self-checking bench for gpu_fill_engine. The reference model expands the
//   requested rectangle into the list of pixels it must produce (min/max,
//   clamp, nested row/column loops) and the bench pops that list as pixels
//   are consumed, checking every cycle's output against the list head.
// -----------------------------------------------------------------------------
module tb_gpu_fill_engine;

  localparam int MAX_X = 639;
  localparam int MAX_Y = 479;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       start_i, abort_i, line_active_i;
  logic [9:0] x1_i, x2_i;
  logic [8:0] y1_i, y2_i;
  logic [9:0] x_fill_o;
  logic [8:0] y_fill_o;
  logic       fill_active, busy_o, done_o;

  int checks = 0;
  int errors = 0;

  gpu_fill_engine dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .start_i       (start_i),
    .abort_i       (abort_i),
    .x1_i          (x1_i),
    .y1_i          (y1_i),
    .x2_i          (x2_i),
    .y2_i          (y2_i),
    .line_active_i (line_active_i),
    .x_fill_o      (x_fill_o),
    .y_fill_o      (y_fill_o),
    .fill_active   (fill_active),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  always #5 clk = ~clk;

  // Drive one fill request and follow it to completion or abort.
  //   stall_pct   : random percentage of cycles with line_active_i high
  //   stall_pixel : index of a pixel to hold for stall_len cycles (-1: none)
  //   abort_after : abort while this many pixels have been consumed (-1: none)
  //   disturb     : scramble corners and toggle start_i while filling
  task automatic run_fill(input string name, input int x1, input int y1,
                          input int x2, input int y2, input int stall_pct,
                          input int stall_pixel, input int stall_len,
                          input int abort_after, input bit disturb);
    int ex[$];
    int ey[$];
    int xmin, xmax, ymin, ymax;
    int total, consumed, active_cycles, stalls, pixel_stalls, budget;
    bit stall, aborted;

    xmin = (x1 < x2) ? x1 : x2;  xmax = (x1 < x2) ? x2 : x1;
    ymin = (y1 < y2) ? y1 : y2;  ymax = (y1 < y2) ? y2 : y1;
    if (xmin > MAX_X) xmin = MAX_X;
    if (xmax > MAX_X) xmax = MAX_X;
    if (ymin > MAX_Y) ymin = MAX_Y;
    if (ymax > MAX_Y) ymax = MAX_Y;
    for (int y = ymin; y <= ymax; y++)
      for (int x = xmin; x <= xmax; x++) begin
        ex.push_back(x);
        ey.push_back(y);
      end
    total = ex.size();
    consumed = 0; active_cycles = 0; stalls = 0; pixel_stalls = 0;
    aborted = 1'b0;
    budget = 4 * total + stall_len + 20;

    x1_i = 10'(x1); y1_i = 9'(y1); x2_i = 10'(x2); y2_i = 9'(y2);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;

    checks++;
    if (fill_active !== 1'b1)
      $display("FAIL %s start_latency: fill_active=%b required 1", name, fill_active);

    while (fill_active === 1'b1 && budget > 0) begin
      budget--;
      active_cycles++;
      if (ex.size() == 0) begin
        errors++;
        $display("FAIL %s overrun: fill_active still 1 after %0d pixels", name, total);
        break;
      end
      checks++;
      if (x_fill_o !== 10'(ex[0]) || y_fill_o !== 9'(ey[0]) ||
          busy_o !== 1'b1 || done_o !== 1'b0) begin
        errors++;
        $display("FAIL %s pixel%0d: got (%0d,%0d) busy=%b done=%b required (%0d,%0d) busy=1 done=0",
                 name, consumed, x_fill_o, y_fill_o, busy_o, done_o, ex[0], ey[0]);
      end

      if (abort_after >= 0 && consumed == abort_after) begin
        abort_i = 1'b1;
        line_active_i = 1'($urandom_range(0, 1));
        aborted = 1'b1;
        stall = 1'b0;
      end else begin
        if (consumed == stall_pixel && pixel_stalls < stall_len) begin
          stall = 1'b1;
          pixel_stalls++;
        end else begin
          stall = ($urandom_range(0, 99) < stall_pct);
        end
        line_active_i = stall;
        if (stall) stalls++;
      end
      if (disturb) begin
        x1_i = 10'($urandom); y1_i = 9'($urandom);
        x2_i = 10'($urandom); y2_i = 9'($urandom);
        start_i = 1'($urandom_range(0, 1));
      end

      @(posedge clk); #1;
      if (aborted) break;
      if (!stall) begin
        void'(ex.pop_front());
        void'(ey.pop_front());
        consumed++;
      end
    end

    abort_i = 1'b0;
    line_active_i = 1'b0;
    start_i = 1'b0;

    if (aborted) begin
      checks++;
      if (fill_active !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
        errors++;
        $display("FAIL %s abort: fill_active=%b busy=%b done=%b required 0 0 0",
                 name, fill_active, busy_o, done_o);
      end
      @(posedge clk); #1;
      checks++;
      if (done_o !== 1'b0 || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL %s abort_late: done=%b busy=%b required 0 0", name, done_o, busy_o);
      end
    end else begin
      checks++;
      if (budget == 0 || ex.size() != 0) begin
        errors++;
        $display("FAIL %s completion: %0d pixels left, budget=%0d required 0 left", name,
                 ex.size(), budget);
      end
      checks++;
      if (active_cycles != total + stalls) begin
        errors++;
        $display("FAIL %s active_cycles: got %0d required %0d", name, active_cycles,
                 total + stalls);
      end
      checks++;
      if (done_o !== 1'b1 || busy_o !== 1'b1 || fill_active !== 1'b0) begin
        errors++;
        $display("FAIL %s done_pulse: done=%b busy=%b fill_active=%b required 1 1 0",
                 name, done_o, busy_o, fill_active);
      end
      @(posedge clk); #1;
      checks++;
      if (done_o !== 1'b0 || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL %s after_done: done=%b busy=%b required 0 0", name, done_o, busy_o);
      end
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (x_fill_o !== 10'd0 || y_fill_o !== 9'd0 || fill_active !== 1'b0 ||
        busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL %s: x=%0d y=%0d fill_active=%b busy=%b done=%b required all 0",
               name, x_fill_o, y_fill_o, fill_active, busy_o, done_o);
    end
  endtask

  task automatic test_reset();
    check_idle("reset_values");
  endtask

  task automatic test_basic();
    run_fill("basic", 2, 3, 4, 4, 0, -1, 0, -1, 1'b0);
    run_fill("swapped", 4, 4, 2, 3, 0, -1, 0, -1, 1'b0);
    run_fill("single_point", 7, 7, 7, 7, 0, -1, 0, -1, 1'b0);
  endtask

  task automatic test_stall();
    run_fill("stall_3x1", 10, 5, 12, 5, 0, 1, 2, -1, 1'b0);
  endtask

  task automatic test_abort();
    run_fill("abort_4x4", 20, 30, 23, 33, 0, -1, 0, 2, 1'b1);
    run_fill("restart", 1, 1, 2, 2, 0, -1, 0, -1, 1'b0);
  endtask

  task automatic test_clamp();
    run_fill("clamp_x", 1000, 2, 636, 3, 0, -1, 0, -1, 1'b0);
    run_fill("clamp_y", 5, 500, 6, 478, 0, -1, 0, -1, 1'b0);
  endtask

  task automatic test_random();
    int x1, y1;
    for (int i = 0; i < 12; i++) begin
      x1 = int'($urandom_range(0, 1023));
      y1 = int'($urandom_range(0, 511));
      run_fill($sformatf("random%0d", i), x1, y1,
               x1 ^ int'($urandom_range(0, 7)), y1 ^ int'($urandom_range(0, 3)),
               int'($urandom_range(0, 40)), -1, 0, -1, 1'b1);
    end
  endtask

  task automatic test_reset_mid_fill();
    x1_i = 10'd50; y1_i = 9'd60; x2_i = 10'd54; y2_i = 9'd62;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    n_rst = 1'b0;
    #1;
    check_idle("reset_mid_fill");
    @(posedge clk); #1;
    check_idle("reset_held");
    n_rst = 1'b1;
    @(posedge clk); #1;
    check_idle("reset_release");
  endtask

  initial begin
    n_rst = 1'b0;
    start_i = 1'b0; abort_i = 1'b0; line_active_i = 1'b0;
    x1_i = '0; y1_i = '0; x2_i = '0; y2_i = '0;
    #3;
    test_reset();
    @(posedge clk); #1;
    n_rst = 1'b1;
    @(posedge clk); #1;
    test_basic();
    test_stall();
    test_abort();
    test_clamp();
    test_random();
    test_reset_mid_fill();
    run_fill("post_reset", 3, 3, 4, 3, 0, -1, 0, -1, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_gpu_fill_engine
